snake_motion: RTL and testbench

Parametrised snake movement and body engine: on each game `step`, it advances the head one cell in the buffered joystick direction. It shifts a body trail of up to `MAX_LEN` segments, grows on request and detects self-collision (and wall collision when enabled). It sits between the button synchroniser and the game controller/renderer and replaces the single-head mover with a full-body, any-grid-size generation.

---
 rtl/snake_motion_if.sv | 35 +++
 rtl/snake_motion.sv | 155 +++++++++++++++
 tb/tb_snake_motion.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_motion_if.sv
// rtl/snake_motion_if.sv - control, status and segment-read signals of the snake motion engine.
`timescale 1ns/1ps
interface snake_motion_if #(
    parameter int XW = 4,
    parameter int YW = 3,
    parameter int LW = 5
) ();
    logic          step;
    logic          lock;
    logic          btn_up;
    logic          btn_down;
    logic          btn_left;
    logic          btn_right;
    logic          grow;
    logic [LW-1:0] rd_idx;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [1:0]    dir;
    logic [LW-1:0] length;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          rd_valid;
    logic          step_done;
    logic          dead;

    modport master (
        output step, lock, btn_up, btn_down, btn_left, btn_right, grow, rd_idx,
        input  head_x, head_y, dir, length, rd_x, rd_y, rd_valid, step_done, dead
    );

    modport slave (
        input  step, lock, btn_up, btn_down, btn_left, btn_right, grow, rd_idx,
        output head_x, head_y, dir, length, rd_x, rd_y, rd_valid, step_done, dead
    );
endinterface

// File: rtl/snake_motion.sv
// rtl/snake_motion.sv - snake head/body mover with growth and collision; SNAKE_WALL_EN makes grid edges lethal.
`timescale 1ns/1ps
module snake_motion #(
    parameter int WIDTH    = 16,
    parameter int HEIGHT   = 8,
    parameter int XW       = 4,
    parameter int YW       = 3,
    parameter int MAX_LEN  = 16,
    parameter int LW       = 5,
    parameter int INIT_LEN = 3
) (
    input  logic          clk,
    input  logic          reset,
    snake_motion_if.slave bus
);
    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    logic [XW-1:0] seg_x_q [MAX_LEN];
    logic [XW-1:0] seg_x_d [MAX_LEN];
    logic [YW-1:0] seg_y_q [MAX_LEN];
    logic [YW-1:0] seg_y_d [MAX_LEN];
    logic [1:0]    dir_q, dir_d, pend_q, pend_d, cand;
    logic          grow_pend_q, grow_pend_d, dead_q, dead_d, step_done_q;
    logic [LW-1:0] len_q, len_d, chk_len;
    logic [XW-1:0] rd_x_q, rd_x_d, nx;
    logic [YW-1:0] rd_y_q, rd_y_d, ny;
    logic          rd_valid_q, rd_valid_d;
    logic          accept, btn_any, self_hit, hit;

    assign accept  = bus.step & ~bus.lock & ~dead_q;
    assign btn_any = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;

    always_comb begin
        if (bus.btn_up)          cand = DIR_UP;
        else if (bus.btn_down)   cand = DIR_DOWN;
        else if (bus.btn_left)   cand = DIR_LEFT;
        else                     cand = DIR_RIGHT;
    end

    always_comb begin
        nx = seg_x_q[0];
        ny = seg_y_q[0];
        case (pend_q)
            DIR_RIGHT: nx = (seg_x_q[0] == XW'(WIDTH-1))  ? '0 : seg_x_q[0] + XW'(1);
            DIR_DOWN:  ny = (seg_y_q[0] == YW'(HEIGHT-1)) ? '0 : seg_y_q[0] + YW'(1);
            DIR_LEFT:  nx = (seg_x_q[0] == '0) ? XW'(WIDTH-1)  : seg_x_q[0] - XW'(1);
            default:   ny = (seg_y_q[0] == '0) ? YW'(HEIGHT-1) : seg_y_q[0] - YW'(1);
        endcase
    end

    // The tail cell only counts as an obstacle when it is not about to be vacated.
    always_comb begin
        chk_len  = grow_pend_q ? len_q : len_q - LW'(1);
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LW'(i) < chk_len && seg_x_q[i] == nx && seg_y_q[i] == ny) self_hit = 1'b1;
        end
    end

`ifdef SNAKE_WALL_EN
    logic off_edge;
    always_comb begin
        case (pend_q)
            DIR_RIGHT: off_edge = (seg_x_q[0] == XW'(WIDTH-1));
            DIR_DOWN:  off_edge = (seg_y_q[0] == YW'(HEIGHT-1));
            DIR_LEFT:  off_edge = (seg_x_q[0] == '0);
            default:   off_edge = (seg_y_q[0] == '0);
        endcase
    end
    assign hit = self_hit | off_edge;
`else
    assign hit = self_hit;
`endif

    always_comb begin
        seg_x_d = seg_x_q;
        seg_y_d = seg_y_q;
        dir_d   = dir_q;
        len_d   = len_q;
        dead_d  = dead_q;
        pend_d  = pend_q;
        if (accept) begin
            if (hit) begin
                dead_d = 1'b1;
            end else begin
                dir_d = pend_q;
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = nx;
                seg_y_d[0] = ny;
                if (grow_pend_q && len_q != LW'(MAX_LEN)) len_d = len_q + LW'(1);
            end
        end
        // Reversal is judged against the direction committed before this edge.
        if (btn_any && cand != (dir_q ^ 2'b10)) pend_d = cand;
        grow_pend_d = (bus.grow && len_q != LW'(MAX_LEN)) | (grow_pend_q & ~accept);
    end

    always_comb begin
        rd_valid_d = (bus.rd_idx < len_d);
        rd_x_d     = '0;
        rd_y_d     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (rd_valid_d && LW'(i) == bus.rd_idx) begin
                rd_x_d = seg_x_d[i];
                rd_y_d = seg_y_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < INIT_LEN) ? XW'(INIT_LEN - 1 - i) : '0;
                seg_y_q[i] <= '0;
            end
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            grow_pend_q <= 1'b0;
            len_q       <= LW'(INIT_LEN);
            dead_q      <= 1'b0;
            step_done_q <= 1'b0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            seg_x_q     <= seg_x_d;
            seg_y_q     <= seg_y_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            grow_pend_q <= grow_pend_d;
            len_q       <= len_d;
            dead_q      <= dead_d;
            step_done_q <= accept;
            rd_x_q      <= rd_x_d;
            rd_y_q      <= rd_y_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign bus.head_x    = seg_x_q[0];
    assign bus.head_y    = seg_y_q[0];
    assign bus.dir       = dir_q;
    assign bus.length    = len_q;
    assign bus.rd_x      = rd_x_q;
    assign bus.rd_y      = rd_y_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.step_done = step_done_q;
    assign bus.dead      = dead_q;
endmodule

// File: tb/tb_snake_motion.sv
// tb/tb_snake_motion.sv - scoreboard bench for snake_motion against a queue-based snake model.
`timescale 1ns/1ps
module tb_snake_motion;
    localparam int W  = 16;
    localparam int H  = 8;
    localparam int ML = 16;
    localparam int IL = 3;
    localparam int XW = 4;
    localparam int YW = 3;
    localparam int LW = 5;

    typedef struct { int x; int y; } cell_t;
    typedef struct { int due; int hx; int hy; int dir; int len; int dead; int rx; int ry; int rv; } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_wraps = 0;

    cell_t body[$];
    int    m_dir, m_pend;
    bit    m_gp, m_dead;
    exp_t  sbq[$];

    snake_motion_if #(.XW(XW), .YW(YW), .LW(LW)) bus ();

    snake_motion #(
        .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .MAX_LEN(ML), .LW(LW), .INIT_LEN(IL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string nm, int act, int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d required %0d", nm, act, req);
    endtask

    task automatic model_reset();
        cell_t c;
        body.delete();
        for (int i = 0; i < IL; i++) begin
            c.x = IL - 1 - i;
            c.y = 0;
            body.push_back(c);
        end
        m_dir  = 0;
        m_pend = 0;
        m_gp   = 0;
        m_dead = 0;
        sbq.delete();
    endtask

    task automatic model_edge(bit st, bit lk, bit g, bit [3:0] btn, int idx);
        int    odir, olen, d, n, cand;
        bit    ogp, acc, off, hit;
        cell_t nh;
        exp_t  e;
        odir = m_dir;
        olen = body.size();
        ogp  = m_gp;
        acc  = st && !lk && !m_dead;
        if (acc) begin
            d    = m_pend;
            nh   = body[0];
            case (d)
                0: nh.x++;
                1: nh.y++;
                2: nh.x--;
                default: nh.y--;
            endcase
            off  = (nh.x < 0 || nh.x >= W || nh.y < 0 || nh.y >= H);
            nh.x = (nh.x + W) % W;
            nh.y = (nh.y + H) % H;
            n    = ogp ? olen : olen - 1;
            hit  = 0;
            for (int i = 0; i < n; i++) if (body[i].x == nh.x && body[i].y == nh.y) hit = 1;
`ifdef SNAKE_WALL_EN
            if (off) hit = 1;
`else
            if (off) n_wraps++;
`endif
            if (hit) begin
                m_dead = 1;
            end else begin
                body.push_front(nh);
                if (!ogp || body.size() > ML) void'(body.pop_back());
                m_dir = d;
            end
            e.due  = cyc + 1;
            e.hx   = body[0].x;
            e.hy   = body[0].y;
            e.dir  = m_dir;
            e.len  = body.size();
            e.dead = m_dead;
            e.rv   = (idx < body.size()) ? 1 : 0;
            e.rx   = e.rv ? body[idx].x : 0;
            e.ry   = e.rv ? body[idx].y : 0;
            sbq.push_back(e);
        end
        if (btn != 4'b0) begin
            if (btn[3])      cand = 3;
            else if (btn[2]) cand = 1;
            else if (btn[1]) cand = 2;
            else             cand = 0;
            if (cand != (odir ^ 2)) m_pend = cand;
        end
        if (g && olen != ML) m_gp = 1;
        else if (acc)        m_gp = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.step_done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_step_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("sb_due",      cyc,                 e.due);
                chk("sb_head_x",   int'(bus.head_x),    e.hx);
                chk("sb_head_y",   int'(bus.head_y),    e.hy);
                chk("sb_dir",      int'(bus.dir),       e.dir);
                chk("sb_length",   int'(bus.length),    e.len);
                chk("sb_dead",     int'(bus.dead),      e.dead);
                chk("sb_rd_valid", int'(bus.rd_valid),  e.rv);
                chk("sb_rd_x",     int'(bus.rd_x),      e.rx);
                chk("sb_rd_y",     int'(bus.rd_y),      e.ry);
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            chk("missing_step_done", 0, 1);
            void'(sbq.pop_front());
        end
    end

    task automatic clear_inputs();
        bus.step = 0; bus.lock = 0; bus.grow = 0;
        bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
    endtask

    task automatic tick(bit st, bit lk, bit g, bit [3:0] btn, int idx = -1);
        int ri;
        ri = (idx < 0) ? int'($urandom_range(0, ML + 2)) : idx;
        bus.step = st; bus.lock = lk; bus.grow = g;
        bus.btn_up = btn[3]; bus.btn_down = btn[2]; bus.btn_left = btn[1]; bus.btn_right = btn[0];
        bus.rd_idx = LW'(ri);
        model_edge(st, lk, g, btn, ri);
        @(posedge clk);
        #2;
        clear_inputs();
    endtask

    task automatic check_reset(string tag);
        chk({tag, "_head_x"},    int'(bus.head_x),    IL - 1);
        chk({tag, "_head_y"},    int'(bus.head_y),    0);
        chk({tag, "_dir"},       int'(bus.dir),       0);
        chk({tag, "_length"},    int'(bus.length),    IL);
        chk({tag, "_dead"},      int'(bus.dead),      0);
        chk({tag, "_step_done"}, int'(bus.step_done), 0);
        chk({tag, "_rd"},        int'({bus.rd_x, bus.rd_y, bus.rd_valid}), 0);
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        check_reset(tag);
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int r;
        clear_inputs();
        bus.rd_idx = '0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_reset("rst");
        reset = 1'b1;

        repeat (5) tick(1, 0, 0, 4'b0);
        tick(0, 0, 0, 4'b0, 1);
        chk("tp_head_x", int'(bus.head_x), 7);
        chk("tp_head_y", int'(bus.head_y), 0);
        chk("tp_seg1_x", int'(bus.rd_x), 6);
        tick(0, 0, 0, 4'b0, 2);
        chk("tp_seg2_x", int'(bus.rd_x), 5);
        chk("tp_seg2_valid", int'(bus.rd_valid), 1);

        tick(0, 0, 0, 4'b0010);
        tick(1, 0, 0, 4'b0);
        tick(0, 0, 0, 4'b0);
        chk("tp_reverse_dir", int'(bus.dir), 0);
        tick(0, 0, 0, 4'b0100);
        tick(1, 0, 0, 4'b0);
        tick(0, 0, 0, 4'b0);
        chk("tp_down_dir", int'(bus.dir), 1);
        chk("tp_down_y", int'(bus.head_y), 1);
        tick(0, 0, 1, 4'b0);
        tick(1, 0, 0, 4'b0);
        tick(0, 0, 0, 4'b0);
        chk("tp_grow_len", int'(bus.length), 4);

        do_reset("mid");
        tick(0, 0, 1, 4'b0);
        tick(1, 0, 0, 4'b0);
        tick(0, 0, 1, 4'b0);
        tick(1, 0, 0, 4'b0);
        tick(0, 0, 0, 4'b0100);
        tick(1, 0, 0, 4'b0);
        tick(0, 0, 0, 4'b0010);
        tick(1, 0, 0, 4'b0);
        tick(0, 0, 0, 4'b1000);
        tick(1, 0, 0, 4'b0);
        tick(0, 0, 0, 4'b0);
        chk("tp_col_dead", int'(bus.dead), 1);
        chk("tp_col_head", int'({bus.head_x, bus.head_y}), (3 << YW) | 1);
        repeat (3) tick(1, 0, 0, 4'b0);
        chk("tp_col_len", int'(bus.length), 5);

        do_reset("rst2");
        tick(1, 1, 0, 4'b0);
        tick(1, 1, 0, 4'b0100);
        tick(1, 1, 0, 4'b0);
        chk("tp_lock_x", int'(bus.head_x), 2);
        tick(1, 0, 0, 4'b0);
        tick(0, 0, 0, 4'b0);
        chk("tp_unlock_y", int'(bus.head_y), 1);

        do_reset("rst3");
        repeat (13) begin
            tick(0, 0, 1, 4'b0);
            tick(1, 0, 0, 4'b0);
        end
        tick(0, 0, 1, 4'b0);
        chk("tp_max_len", int'(bus.length), ML);
        tick(1, 0, 0, 4'b0);
        tick(0, 0, 0, 4'b0);
        chk("tp_sat_len", int'(bus.length), ML);
`ifdef SNAKE_WALL_EN
        chk("tp_wall_dead", int'(bus.dead), 1);
        chk("tp_wall_x", int'(bus.head_x), 15);
`else
        chk("tp_wrap_dead", int'(bus.dead), 0);
        chk("tp_wrap_x", int'(bus.head_x), 0);
`endif
        tick(0, 0, 0, 4'b0);
        tick(1, 0, 0, 4'b0);
        do_reset("rst_step");

        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 999));
            if (m_dead || r < 3) do_reset("rnd_rst");
            tick($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 {$urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0});
        end

        repeat (3) tick(0, 0, 0, 4'b0);
        chk("sb_drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
